vram_write_port: RTL and testbench
==================================

Name: vram_write_port

Overview:
- Upstream feeder for the video RAM: accepts write requests from the loader/CPU side over a valid/ready handshake.
- Buffers requests in a small FIFO and commits them to VRAM only while the GPU is outside the visible area, so GPU fetches are never disturbed.
- Sits beside gpu_m on the vram address/data/WE nets. Top level muxes vram address onto this block when bus_own=1. The data bus is driven through vram_data_oe. RAM OE is (visible & ~bus_own).

Parameters:
- ADDR_W, 15, VRAM address width
- DATA_W, 8, VRAM data width
- DEPTH, 8, FIFO entries; power of two, >= 2
- LVL_W, 4, width of level output; equals clog2(DEPTH+1)

Ports:
- clk  input  1  single system clock (same as gpu_m); all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- wr_valid  input  1  request valid
- wr_ready  output  1  FIFO can accept
- wr_addr  input  ADDR_W  request address
- wr_data  input  DATA_W  request data
- visible  input  1  from gpu_m; 1 = GPU owns VRAM
- bus_own  output  1  this block drives VRAM address/data
- vram_addr  output  ADDR_W  write address (valid when bus_own)
- vram_data  output  DATA_W  write data (valid when bus_own)
- vram_data_oe  output  1  tri-state enable for vram_data; equals bus_own
- vram_we  output  1  RAM write strobe, active-high
- level  output  LVL_W  FIFO occupancy, 0..DEPTH
- overflow  output  1  sticky: wr_valid seen while wr_ready=0; cleared only by rst

Behaviour:
- Reset state: FIFO empty, level=0, state IDLE.
- Reset outputs: bus_own=0, vram_data_oe=0, vram_we=0, overflow=0, vram_addr=0, vram_data=0. wr_ready=0 while rst=1.
- wr_ready is combinational: (level != DEPTH) & ~rst.
- Push happens when wr_valid & wr_ready at a clock edge. Pushes are in-order; entries are registered {addr,data}.
- When full, wr_ready=0 even if a pop occurs in the same cycle; no push-through-full.
- A simultaneous push and pop (not full) leaves level unchanged.
- Read/write pointers wrap modulo DEPTH.
- FSM states are IDLE, SETUP, STROBE and HOLD. Each state is one cycle; all outputs are registered.
- IDLE: bus_own=0, we=0. Go to SETUP when level!=0 & visible=0.
- SETUP: bus_own=1, addr/data = FIFO head, we=0.
  - visible=1 -> IDLE (abort, entry retained).
  - Otherwise -> STROBE.
- STROBE: bus_own=1, we=1, addr/data held.
  - visible=1 -> IDLE (abort: we drops next cycle, entry retained, retried later).
  - Otherwise pop the head at the end of this cycle -> HOLD.
- HOLD: bus_own=1, we=0, addr/data held (RAM hold time).
  - Next state is always IDLE.
  - If visible=1, bus_own still drops next cycle.
- Back-to-back writes cost 4 cycles per entry; IDLE is always visited between writes.
- A write that completes during blanking is never repeated.
- An aborted write leaves RAM contents undefined at that address only until the retry completes.
- addr/data never change while we=1.
- we=1 only when bus_own=1 in both the current and previous cycle.
- Latency: push at cycle N with empty FIFO and visible=0 -> SETUP at N+1, we=1 at N+2, level decrements at N+3.
- Mid-operation rst: the next cycle is IDLE with the FIFO flushed; we and bus_own go low at that edge, and no write completes.
- level = wr_ptr - rd_ptr including the wrap bit, LVL_W bits.

Test Plan:
- Reset, then push {0x0010,0xA5} with visible=0 -> bus_own=1 at +1. vram_we=1 for exactly one cycle at +2 with addr 0x0010, data 0xA5. level returns to 0 at +3.
- Hold visible=1, push 8 entries -> wr_ready=0 after the 8th, level=8, no bus_own. A 9th wr_valid sets overflow=1 and is dropped.
- Then drop visible -> 8 writes in FIFO order at 4-cycle spacing, one we pulse each. level reaches 0 and wr_ready=1.
- Raise visible in the STROBE cycle -> IDLE next cycle, level unchanged. The same entry is rewritten after visible falls; exactly one completed write per entry.
- Assert rst during SETUP with level=3 -> next cycle bus_own=0, we=0, level=0, overflow=0. No further writes.
- Push and pop in the same cycle at level=4 -> level stays 4. Data order is preserved across pointer wrap (push 12, drain 12, compare).

Source files
------------

// File: rtl/vram_write_port.sv
// VRAM write feeder: buffers write requests in a small FIFO and commits them
// to video RAM only while the GPU is outside the visible area.
module vram_write_port #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int LVL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              visible,
  output logic              bus_own,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_data,
  output logic              vram_data_oe,
  output logic              vram_we,
  output logic [LVL_W-1:0]  level,
  output logic              overflow
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [LVL_W-1:0]  wr_ptr, rd_ptr;
  logic              push, pop;

  logic              bus_own_d, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level    = wr_ptr - rd_ptr;
  assign wr_ready = (level != LVL_W'(DEPTH)) & ~rst;
  assign push     = wr_valid & wr_ready;
  assign pop      = (state == STROBE) & ~visible & ~rst;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr[IDX_W-1:0]] <= wr_addr;
      data_mem[wr_ptr[IDX_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                        overflow <= 1'b0;
    else if (wr_valid && !wr_ready) overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Any sign of the visible area aborts the cycle; the entry stays at the head.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (level != '0 && !visible) state_nxt = SETUP;
      SETUP:   state_nxt = visible ? IDLE : STROBE;
      STROBE:  state_nxt = visible ? IDLE : HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_own_d = (state_nxt != IDLE);
    we_d      = (state_nxt == STROBE);
    addr_d    = vram_addr;
    data_d    = vram_data;
    if (state == IDLE && state_nxt == SETUP) begin
      addr_d = addr_mem[rd_ptr[IDX_W-1:0]];
      data_d = data_mem[rd_ptr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_own   <= 1'b0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
    end else begin
      bus_own   <= bus_own_d;
      vram_we   <= we_d;
      vram_addr <= addr_d;
      vram_data <= data_d;
    end
  end

  assign vram_data_oe = bus_own;

endmodule

// File: tb/tb_vram_write_port.sv
// Directed bench for vram_write_port: latency, fill/overflow, drain order,
// abort/retry, mid-operation reset and pointer wrap.
module tb_vram_write_port;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int LVL_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              visible = 1'b0;
  logic              bus_own;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_data;
  logic              vram_data_oe;
  logic              vram_we;
  logic [LVL_W-1:0]  level;
  logic              overflow;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [ADDR_W+DATA_W-1:0] got_q[$];
  int                       cyc_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  vram_write_port #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .visible(visible),
    .bus_own(bus_own), .vram_addr(vram_addr), .vram_data(vram_data),
    .vram_data_oe(vram_data_oe), .vram_we(vram_we), .level(level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // A write completes when the strobe cycle ends without the GPU reclaiming the bus.
  always @(posedge clk) begin
    cyc++;
    if (vram_we && !visible && !rst) begin
      got_q.push_back({vram_addr, vram_data});
      cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int k = 0;
    while (!wr_ready && k < 200) begin tick(); k++; end
    if (!wr_ready) chk("push_wait_timeout", 32'(wr_ready), 32'd1);
    push1(a, d);
  endtask

  task automatic wait_writes(input int n, input string tag);
    int k = 0;
    while (got_q.size() < n && k < 400) begin tick(); k++; end
    chk(tag, 32'(got_q.size()), 32'(n));
  endtask

  task automatic wait_we(input string tag);
    int k = 0;
    while (!vram_we && k < 50) begin tick(); k++; end
    chk(tag, 32'(vram_we), 32'd1);
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_bus_own", 32'(bus_own), 0);
    chk("rst_oe", 32'(vram_data_oe), 0);
    chk("rst_we", 32'(vram_we), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_ready", 32'(wr_ready), 0);
    chk("rst_addr", 32'(vram_addr), 0);
    chk("rst_data", 32'(vram_data), 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(wr_ready), 1);

    // single write latency
    push1(15'h0010, 8'hA5);
    chk("lat0_level", 32'(level), 1);
    chk("lat0_bus_own", 32'(bus_own), 0);
    tick();
    chk("lat1_bus_own", 32'(bus_own), 1);
    chk("lat1_oe", 32'(vram_data_oe), 1);
    chk("lat1_we", 32'(vram_we), 0);
    tick();
    chk("lat2_we", 32'(vram_we), 1);
    chk("lat2_addr", 32'(vram_addr), 32'h0010);
    chk("lat2_data", 32'(vram_data), 32'hA5);
    chk("lat2_level", 32'(level), 1);
    tick();
    chk("lat3_we", 32'(vram_we), 0);
    chk("lat3_level", 32'(level), 0);
    chk("lat3_bus_own", 32'(bus_own), 1);
    tick();
    chk("lat4_bus_own", 32'(bus_own), 0);
    chk("lat_nwrites", 32'(got_q.size()), 1);
    if (got_q.size() > 0) chk("lat_write", 32'(got_q[0]), 32'({15'h0010, 8'hA5}));

    // fill while visible, then overflow
    got_q.delete(); cyc_q.delete();
    visible = 1'b1;
    for (int i = 0; i < DEPTH; i++) push1(15'(16'h0100 + i), 8'(8'h10 + i));
    chk("full_ready", 32'(wr_ready), 0);
    chk("full_level", 32'(level), 8);
    chk("full_bus_own", 32'(bus_own), 0);
    push1(15'h7FFF, 8'hFF);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 8);

    // drain in order at 4-cycle spacing
    visible = 1'b0;
    wait_writes(DEPTH, "drain_count");
    for (int i = 0; i < DEPTH && i < got_q.size(); i++)
      chk($sformatf("drain_%0d", i), 32'(got_q[i]), 32'({15'(16'h0100 + i), 8'(8'h10 + i)}));
    for (int i = 1; i < DEPTH && i < cyc_q.size(); i++)
      chk($sformatf("spacing_%0d", i), 32'(cyc_q[i] - cyc_q[i-1]), 4);
    chk("drain_level", 32'(level), 0);
    chk("drain_ready", 32'(wr_ready), 1);
    chk("ovf_sticky", 32'(overflow), 1);
    tick(); tick();
    chk("drain_idle", 32'(bus_own), 0);

    // abort in STROBE, then retry
    got_q.delete(); cyc_q.delete();
    push1(15'h0200, 8'h3C);
    wait_we("abort_reach_strobe");
    visible = 1'b1;
    tick();
    chk("abort_bus_own", 32'(bus_own), 0);
    chk("abort_we", 32'(vram_we), 0);
    chk("abort_level", 32'(level), 1);
    tick(); tick();
    chk("abort_hold_off", 32'(bus_own), 0);
    chk("abort_no_write", 32'(got_q.size()), 0);
    visible = 1'b0;
    wait_writes(1, "retry_count");
    if (got_q.size() > 0) chk("retry_write", 32'(got_q[0]), 32'({15'h0200, 8'h3C}));
    repeat (6) tick();
    chk("retry_once", 32'(got_q.size()), 1);
    chk("retry_level", 32'(level), 0);

    // reset during SETUP with three entries queued
    visible = 1'b1;
    for (int i = 0; i < 3; i++) push1(15'(16'h0500 + i), 8'(8'h60 + i));
    chk("mid_level3", 32'(level), 3);
    visible = 1'b0;
    tick();
    chk("mid_setup_own", 32'(bus_own), 1);
    chk("mid_setup_we", 32'(vram_we), 0);
    got_q.delete(); cyc_q.delete();
    rst = 1'b1;
    #1;
    chk("mid_ready_in_rst", 32'(wr_ready), 0);
    tick();
    chk("mid_bus_own", 32'(bus_own), 0);
    chk("mid_we", 32'(vram_we), 0);
    chk("mid_level", 32'(level), 0);
    chk("mid_overflow", 32'(overflow), 0);
    rst = 1'b0;
    repeat (10) tick();
    chk("mid_no_writes", 32'(got_q.size()), 0);
    chk("mid_idle", 32'(bus_own), 0);

    // simultaneous push/pop at level 4, then wrap-around ordering
    got_q.delete(); cyc_q.delete(); exp_q.delete();
    visible = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push1(15'(16'h0300 + i), 8'(8'h40 + i));
      exp_q.push_back({15'(16'h0300 + i), 8'(8'h40 + i)});
    end
    chk("pp_level4", 32'(level), 4);
    visible = 1'b0;
    tick();
    tick();
    chk("pp_strobe", 32'(vram_we), 1);
    push1(15'h0304, 8'h44);
    exp_q.push_back({15'h0304, 8'h44});
    chk("pp_level_same", 32'(level), 4);
    for (int i = 0; i < 12; i++) begin
      push_wait(15'(16'h0400 + i), 8'(8'h80 + i));
      exp_q.push_back({15'(16'h0400 + i), 8'(8'h80 + i)});
    end
    wait_writes(17, "wrap_count");
    for (int i = 0; i < 17 && i < got_q.size(); i++)
      chk($sformatf("wrap_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    chk("wrap_level", 32'(level), 0);
    chk("wrap_ready", 32'(wr_ready), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
